my_if_stream: RTL and testbench
===============================

# my_if_stream

Parameterised byte-stream source that drives the data/valid pair carried on the `my_if` interface. After reset it idles for a programmable number of cycles, then emits a burst of incrementing data beats with `valid` asserted, honouring downstream `ready` back-pressure, and signals completion. It sits at the producer end of a `my_if` link: it either feeds a consumer directly or acts as a synthesizable stimulus source.

## Interface
- `DATA_W`, default 8: width of `data`.
- `START_DELAY`, default 10: idle cycles after reset release before the first beat. Legal range is at least 1.
- `BURST_LEN`, default 10: beats per burst. Legal range is at least 1.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `ready` input, 1 bit: consumer accepts the current beat when `valid && ready`.
- `restart` input, 1 bit: a single-cycle pulse in DONE starts a new burst.
- `data` output, `DATA_W` bits: the beat payload.
- `valid` output, 1 bit: `data` holds a beat.
- `done` output, 1 bit: the burst is complete.
- `beat_cnt` output, `$clog2(BURST_LEN+1)` bits: number of beats accepted in the current burst.

## Operation
- The block has three states: WAIT, RUN and DONE.
- **Reset (`rst_n` = 0, asynchronous):**
  - State = WAIT.
  - `data` = 0, `valid` = 0, `done` = 0, `beat_cnt` = 0.
  - Delay counter = 0.
- **WAIT:**
  - `valid` = 0 and `data` holds 0.
  - The delay counter increments every cycle.
  - On the cycle the counter reaches `START_DELAY`, the state moves to RUN and the block registers `data` = 1 and `valid` = 1.
- **RUN:**
  - `valid` = 1 throughout.
  - If `ready` = 0, `data` holds its value (no beat is lost or skipped).
  - If `ready` = 1, the beat is accepted and `beat_cnt` increments.
  - If the accepted beat is the `BURST_LEN`-th, the state moves to DONE.
  - Otherwise `data` is set to `data` + 1.
- **DONE:**
  - `valid` = 0 and `done` = 1.
  - `data` holds the last beat value; `beat_cnt` holds `BURST_LEN`.
  - When `restart` = 1, the state moves to WAIT and the delay counter, `done` and `beat_cnt` clear.
  - `data` does not reset on restart: it continues from its held value, and the next burst starts at the held value + 1.
- **Arithmetic:**
  - `data` increments modulo 2^`DATA_W`, so 255 wraps to 0 with no flag.
  - Counters saturate at their terminal values.
- `restart` is ignored in WAIT and RUN.
- `ready` is ignored outside RUN.
- Reset asserted at any time, including mid-burst with `valid` high, immediately forces the reset values. The burst is not resumed; the block restarts from WAIT.

## Timing
- All outputs are registered. There is no combinational path from `ready` or `restart` to any output.
- With `ready` held at 1, counting rising edges after `rst_n` deassertion:
  - Edges 1 to `START_DELAY`: `valid` = 0.
  - Edge `START_DELAY`+1: `valid` rises with `data` = 1.
  - Each later edge presents the next value. With the defaults, edges 11 to 20 present `data` = 1 to 10.
  - `done` rises, and `valid` falls, on edge `START_DELAY` + `BURST_LEN` + 1, i.e. edge 21.
- Throughput is one beat per cycle while `ready` = 1.
- Each `ready`-low cycle in RUN adds one cycle of latency.
- After a `restart` pulse on edge N, the first beat appears on edge N + `START_DELAY` + 1.

## Test plan
- **Reset values:** hold `rst_n` = 0 for 3 cycles -> `data` = 0, `valid` = 0, `done` = 0 and `beat_cnt` = 0, set asynchronously before any clock edge.
- **Default burst:** `ready` = 1, release reset -> `valid` = 0 for 10 edges, then `data` = 1..10 with `valid` = 1 on edges 11..20, then `done` = 1, `valid` = 0, `data` = 10 and `beat_cnt` = 10 from edge 21.
- **Back-pressure:** drop `ready` for 3 cycles while `data` = 4 -> `data` stays 4 with `valid` = 1 for those cycles, every value 1..10 appears exactly once as an accepted beat, and `done` is delayed by 3 cycles.
- **Mid-burst reset:** assert `rst_n` = 0 asynchronously while `data` = 6 -> outputs clear immediately; after release the full 10-cycle WAIT repeats and the burst restarts at 1.
- **Restart:** in DONE with `data` = 10, pulse `restart` -> `done` clears, and after 10 idle cycles `data` = 11..20 is emitted. Pulses of `restart` during RUN have no effect.
- **Wrap-around:** run bursts until `data` = 255, then accept one more beat -> the next beat is `data` = 0 with `valid` = 1.

Source files
------------

// File: rtl/my_if_stream.sv
// my_if_stream: byte-stream source that idles, emits an incrementing burst
// under ready back-pressure, then waits in DONE for a restart pulse.
module my_if_stream #(
  parameter int DATA_W      = 8,
  parameter int START_DELAY = 10,
  parameter int BURST_LEN   = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ready,
  input  logic                             restart,
  output logic [DATA_W-1:0]                data,
  output logic                             valid,
  output logic                             done,
  output logic [$clog2(BURST_LEN+1)-1:0]   beat_cnt
);
  localparam int DW = $clog2(START_DELAY + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [DW-1:0] DLY_END = DW'(START_DELAY);
  localparam logic [BW-1:0] BL_LAST = BW'(BURST_LEN - 1);
  typedef enum logic [1:0] {S_WAIT, S_RUN, S_DONE} state_t;
  state_t            state_q, state_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [BW-1:0]     beat_q, beat_d;
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    beat_d  = beat_q;
    case (state_q)
      S_WAIT: begin
        valid_d = 1'b0;
        dly_d   = (dly_q == DLY_END) ? dly_q : dly_q + 1'b1;
        // data continues from its held value, so bursts after restart carry on
        if (dly_q == DLY_END) begin
          state_d = S_RUN;
          data_d  = data_q + 1'b1;
          valid_d = 1'b1;
        end
      end
      S_RUN: if (ready) begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BL_LAST) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else data_d = data_q + 1'b1;
      end
      S_DONE: if (restart) begin
        state_d = S_WAIT;
        dly_d   = '0;
        done_d  = 1'b0;
        beat_d  = '0;
      end
      default: state_d = S_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      beat_q  <= beat_d;
    end
  end
  assign data     = data_q;
  assign valid    = valid_q;
  assign done     = done_q;
  assign beat_cnt = beat_q;
endmodule

// File: tb/tb_my_if_stream.sv
// tb_my_if_stream: directed bench for my_if_stream with default parameters.
module tb_my_if_stream;
  logic       clk = 1'b0, rst_n = 1'b1, ready = 1'b1, restart = 1'b0;
  logic [7:0] data;
  logic       valid, done;
  logic [3:0] beat_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  my_if_stream dut (
    .clk(clk), .rst_n(rst_n), .ready(ready), .restart(restart),
    .data(data), .valid(valid), .done(done), .beat_cnt(beat_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, beat_cnt, 0);
  endtask
  // Starts right after reset release or the restart edge; models one burst.
  task automatic burst(input logic [7:0] first, input int stall_at, input int stall_n,
                       input int rs_at, input int abort_at);
    logic [7:0] e;
    int k, n, stalls;
    e = first; k = 0; n = 0; stalls = stall_n;
    for (int i = 0; i < 10; i++) begin
      step; n++;
      chk("wait_valid", valid, 0);
      chk("wait_data", data, 8'(first - 8'd1));
    end
    step; n++;
    while (k < 10) begin
      chk("run_valid", valid, 1);
      chk("run_data", data, e);
      chk("run_cnt", beat_cnt, k);
      chk("run_done", done, 0);
      if (int'(e) == abort_at) return;
      restart = (int'(e) == rs_at);
      ready = !(int'(e) == stall_at && stalls > 0);
      if (!ready) stalls--;
      step; n++;
      restart = 1'b0;
      if (ready) begin
        k++;
        e++;
      end
      ready = 1'b1;
    end
    chk("done_flag", done, 1);
    chk("done_valid", valid, 0);
    chk("done_data", data, 8'(e - 8'd1));
    chk("done_cnt", beat_cnt, 10);
    chk("done_edge", n, 21 + stall_n);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    repeat (3) step;
    chk_zero("rst_hold");
    rst_n = 1'b1;
    burst(8'd1, -1, 0, -1, -1);
    ready = 1'b0;
    step;
    chk("hold_done", done, 1);
    chk("hold_data", data, 10);
    chk("hold_cnt", beat_cnt, 10);
    chk("hold_valid", valid, 0);
    ready = 1'b1;
    restart = 1'b1;
    step;
    restart = 1'b0;
    chk("rs_done", done, 0);
    chk("rs_cnt", beat_cnt, 0);
    chk("rs_valid", valid, 0);
    chk("rs_data", data, 10);
    burst(8'd11, -1, 0, 15, -1);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    burst(8'd1, -1, 0, -1, 6);
    #3 rst_n = 1'b0;
    #1 chk_zero("mid_rst");
    step;
    step;
    rst_n = 1'b1;
    burst(8'd1, 4, 3, -1, -1);
    for (int f = 11; f <= 251; f += 10) begin
      restart = 1'b1;
      step;
      restart = 1'b0;
      burst(8'(f), -1, 0, -1, -1);
    end
    chk("wrap_end", data, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
